// File: rtl/inertia_term_gen_pkg.sv
// Shared widths, FSM encoding and fixed-point constants for the inertia term path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package inertia_term_gen_pkg;

    localparam int COORD_W    = 11;              // u6c5f coordinates
    localparam int TERM_W     = 23;              // s13c9f tensor terms
    localparam int CNT_W      = 16;              // per-frame point counter
    localparam int FRAC_SHIFT = 1;               // 10 product fraction bits -> 9 term fraction bits
    localparam int LAT        = 3;               // point-in to term_ce latency
    localparam int DIFF_W     = COORD_W + 1;     // s6c5f centroid offset
    localparam int PROD_W     = 2 * DIFF_W;      // raw signed product

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Unsigned coordinate minus unsigned centroid as a signed offset; never overflows.
    function automatic logic signed [DIFF_W-1:0] coord_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/inertia_term_gen_term_mult.sv
// Signed multiply, optional negate and arithmetic right shift for one tensor term.
// Latency: 2 ce-qualified cycles (product register, then shifted term register).
// Backpressure: none; ce=0 freezes both stages.
module term_mult
    import inertia_term_gen_pkg::*;
#(
    parameter bit NEG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic signed [DIFF_W-1:0] a,
    input  logic signed [DIFF_W-1:0] b,
    output logic signed [TERM_W-1:0] p
);

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_sel;
    logic signed [TERM_W-1:0] prod_shr;

    // Negation happens before the shift so the floor applies to the negated value;
    // |prod| < 2^22, so negating inside PROD_W bits cannot overflow.
    always_comb begin
        prod_sel = NEG ? -prod : prod;
        prod_shr = TERM_W'(prod_sel >>> FRAC_SHIFT);
    end

    // Two pipeline registers: raw product, then the scaled term.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod <= '0;
            p    <= '0;
        end else if (ce) begin
            prod <= PROD_W'(a) * PROD_W'(b);
            p    <= prod_shr;
        end
    end

endmodule

// File: rtl/inertia_term_gen.sv
// Centroid subtraction plus dy^2, dx^2, -dx*dy terms and accumulator control for one frame.
// Latency: 3 ce-qualified cycles from accepted point to term_ce.
// Backpressure: none; points are accepted every cycle in RUN, ce=0 freezes everything.
module inertia_term_gen
    import inertia_term_gen_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     pt_valid,
    input  logic [COORD_W-1:0]       pt_x,
    input  logic [COORD_W-1:0]       pt_y,
    input  logic [COORD_W-1:0]       cx,
    input  logic [COORD_W-1:0]       cy,
    output logic signed [TERM_W-1:0] term_xx,
    output logic signed [TERM_W-1:0] term_yy,
    output logic signed [TERM_W-1:0] term_xy,
    output logic                     term_ce,
    output logic                     acc_clr,
    output logic                     frame_done,
    output logic                     busy,
    output logic [CNT_W-1:0]         pt_count
);

    state_t                   state;
    state_t                   state_nxt;
    logic [1:0]               drain_cnt;
    logic [COORD_W-1:0]       cx_l;
    logic [COORD_W-1:0]       cy_l;
    logic [COORD_W-1:0]       cx_use;
    logic [COORD_W-1:0]       cy_use;
    logic signed [DIFF_W-1:0] dx;
    logic signed [DIFF_W-1:0] dy;
    logic                     v1;
    logic                     v2;
    logic                     accept;

    // A point on the frame_start cycle belongs to the new frame, so it sees the incoming centroid.
    always_comb begin
        accept = pt_valid && (frame_start || (state == ST_RUN));
        cx_use = frame_start ? cx : cx_l;
        cy_use = frame_start ? cy : cy_l;
    end

    // Next-state logic; frame_start overrides everything, including a coincident frame_end.
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_RUN:   if (frame_end) state_nxt = ST_DRAIN;
                ST_DRAIN: if (drain_cnt == 2'(LAT - 1)) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register and drain counter; DRAIN lasts LAT cycles so the last term has left S3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else if (ce) begin
            state <= state_nxt;
            if (state != ST_DRAIN || frame_start) drain_cnt <= '0;
            else                                  drain_cnt <= drain_cnt + 2'd1;
        end
    end

    // Centroid latch, S1 offsets, valid chain, clear strobe and point counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx_l     <= '0;
            cy_l     <= '0;
            dx       <= '0;
            dy       <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            term_ce  <= 1'b0;
            acc_clr  <= 1'b0;
            pt_count <= '0;
        end else if (ce) begin
            if (frame_start) begin
                cx_l <= cx;
                cy_l <= cy;
            end
            dx      <= coord_diff(pt_x, cx_use);
            dy      <= coord_diff(pt_y, cy_use);
            // Restart drops every in-flight point of the old frame.
            v1      <= accept;
            v2      <= frame_start ? 1'b0 : v1;
            term_ce <= frame_start ? 1'b0 : v2;
            acc_clr <= frame_start;
            if (frame_start)                   pt_count <= accept ? CNT_W'(1) : '0;
            else if (accept && !(&pt_count))   pt_count <= pt_count + CNT_W'(1);
        end
    end

    always_comb begin
        busy       = (state == ST_RUN) || (state == ST_DRAIN);
        frame_done = (state == ST_DONE);
    end

    term_mult #(.NEG(1'b0)) u_mult_xx (
        .clk (clk), .rst (rst), .ce (ce), .a (dy), .b (dy), .p (term_xx)
    );

    term_mult #(.NEG(1'b0)) u_mult_yy (
        .clk (clk), .rst (rst), .ce (ce), .a (dx), .b (dx), .p (term_yy)
    );

    term_mult #(.NEG(1'b1)) u_mult_xy (
        .clk (clk), .rst (rst), .ce (ce), .a (dx), .b (dy), .p (term_xy)
    );

endmodule

// File: tb/tb_inertia_term_gen.sv
// Directed-vector bench for inertia_term_gen with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_inertia_term_gen;
    import inertia_term_gen_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     ce;
    logic                     frame_start;
    logic                     frame_end;
    logic                     pt_valid;
    logic [COORD_W-1:0]       pt_x;
    logic [COORD_W-1:0]       pt_y;
    logic [COORD_W-1:0]       cx;
    logic [COORD_W-1:0]       cy;
    logic signed [TERM_W-1:0] term_xx;
    logic signed [TERM_W-1:0] term_yy;
    logic signed [TERM_W-1:0] term_xy;
    logic                     term_ce;
    logic                     acc_clr;
    logic                     frame_done;
    logic                     busy;
    logic [CNT_W-1:0]         pt_count;

    int n_chk  = 0;
    int n_fail = 0;

    inertia_term_gen dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pt_valid    (pt_valid),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .cx          (cx),
        .cy          (cy),
        .term_xx     (term_xx),
        .term_yy     (term_yy),
        .term_xy     (term_xy),
        .term_ce     (term_ce),
        .acc_clr     (acc_clr),
        .frame_done  (frame_done),
        .busy        (busy),
        .pt_count    (pt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse frame_end and measure cycles until frame_done, then return to IDLE.
    task automatic finish_frame(input string tag);
        int n;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        n = 1;
        while (!frame_done && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_done_lat"}, n, 4);
        tick();
        chk({tag, "_done_pulse"}, frame_done, 0);
    endtask

    // One frame holding a single point; checks the three terms when term_ce rises.
    task automatic single(input string tag,
                          input logic [COORD_W-1:0] ccx, input logic [COORD_W-1:0] ccy,
                          input logic [COORD_W-1:0] px,  input logic [COORD_W-1:0] py,
                          input int exx, input int eyy, input int exy);
        frame_start = 1'b1; cx = ccx; cy = ccy;
        tick();
        frame_start = 1'b0;
        chk({tag, "_acc_clr"}, acc_clr, 1);
        pt_valid = 1'b1; pt_x = px; pt_y = py;
        tick();
        pt_valid = 1'b0;
        chk({tag, "_clr_one_cycle"}, acc_clr, 0);
        tick();
        chk({tag, "_ce_early"}, term_ce, 0);
        tick();
        chk({tag, "_term_ce"}, term_ce, 1);
        chk({tag, "_xx"}, term_xx, exx);
        chk({tag, "_yy"}, term_yy, eyy);
        chk({tag, "_xy"}, term_xy, exy);
        finish_frame(tag);
    endtask

    initial begin
        int ce_seen;
        int first_ce;
        int last_ce;
        int done_at;
        int spurious;

        rst = 1'b0; ce = 1'b1; frame_start = 1'b0; frame_end = 1'b0; pt_valid = 1'b0;
        pt_x = '0; pt_y = '0; cx = '0; cy = '0;
        tick();
        chk("rst_term_xx", term_xx, 0);
        chk("rst_term_ce", term_ce, 0);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pt_count", pt_count, 0);
        rst = 1'b1;
        tick();

        // frame_end and stray points in IDLE are ignored.
        frame_end = 1'b1; pt_valid = 1'b1;
        tick();
        frame_end = 1'b0; pt_valid = 1'b0;
        tick();
        chk("idle_fe_busy", busy, 0);
        chk("idle_pt_count", pt_count, 0);

        // dx=64, dy=-64 -> 4096 products, scaled by 1/2.
        single("basic", 11'd256, 11'd160, 11'd320, 11'd96, 2048, 2048, 2048);
        // dx=dy=1: +1>>>1=0, -1>>>1=-1.
        single("round", 11'd0, 11'd0, 11'd1, 11'd1, 0, 0, -1);
        // dx=2047, dy=-2047: 4190209>>>1 = 2095104.
        single("ext_a", 11'd0, 11'd2047, 11'd2047, 11'd0, 2095104, 2095104, 2095104);
        // -4190209>>>1 = -2095105.
        single("ext_b", 11'd0, 11'd0, 11'd2047, 11'd2047, 2095104, 2095104, -2095105);

        // Streaming: point k at (8k, 4), centroid 0 -> xx=8, yy=32k^2, xy=-16k.
        frame_start = 1'b1; cx = 11'd0; cy = 11'd0;
        tick();
        frame_start = 1'b0;
        ce_seen = 0; first_ce = -1; last_ce = -1; done_at = -1;
        for (int c = 0; c < 16; c++) begin
            pt_valid  = (c < 10);
            pt_x      = 11'(8 * c);
            pt_y      = 11'd4;
            frame_end = (c == 9);
            tick();
            if (term_ce) begin
                if (first_ce < 0) first_ce = c;
                last_ce = c;
                chk($sformatf("stream_yy%0d", ce_seen), term_yy, 32 * ce_seen * ce_seen);
                chk($sformatf("stream_xy%0d", ce_seen), term_xy, -16 * ce_seen);
                ce_seen++;
            end
            if (frame_done && done_at < 0) done_at = c;
            if (c == 11) chk("stream_busy_drain", busy, 1);
            if (c == 12) chk("stream_busy_done", busy, 0);
        end
        pt_valid = 1'b0; frame_end = 1'b0;
        chk("stream_ce_count", ce_seen, 10);
        chk("stream_first_ce", first_ce, 2);
        chk("stream_last_ce", last_ce, 11);
        chk("stream_done_at", done_at, 12);
        chk("stream_pt_count", pt_count, 10);

        // Restart mid-frame: two points in flight are dropped.
        frame_start = 1'b1; cx = 11'd100; cy = 11'd100;
        tick();
        frame_start = 1'b0;
        pt_valid = 1'b1; pt_x = 11'd200; pt_y = 11'd100;
        tick();
        tick();
        pt_valid = 1'b0;
        chk("restart_pre_count", pt_count, 2);
        frame_start = 1'b1; cx = 11'd200; cy = 11'd100;
        tick();
        frame_start = 1'b0;
        chk("restart_acc_clr", acc_clr, 1);
        chk("restart_pt_count", pt_count, 0);
        spurious = int'(term_ce);
        pt_valid = 1'b1; pt_x = 11'd210; pt_y = 11'd110;
        tick();
        pt_valid = 1'b0;
        spurious += int'(term_ce);
        tick();
        spurious += int'(term_ce);
        chk("restart_no_stale_ce", spurious, 0);
        tick();
        chk("restart_ce", term_ce, 1);
        chk("restart_xx", term_xx, 50);
        chk("restart_yy", term_yy, 50);
        chk("restart_xy", term_xy, -50);
        chk("restart_count1", pt_count, 1);

        // Reset while draining: outputs clear at once and no frame_done follows.
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        chk("drain_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_term_yy", term_yy, 0);
        chk("arst_pt_count", pt_count, 0);
        chk("arst_frame_done", frame_done, 0);
        tick();
        rst = 1'b1;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            spurious += int'(frame_done) + int'(busy);
        end
        chk("arst_no_done", spurious, 0);

        // ce freeze mid-pipeline: point (4,2) vs origin -> xx=2, yy=8, xy=-4.
        frame_start = 1'b1; cx = 11'd0; cy = 11'd0;
        tick();
        frame_start = 1'b0;
        pt_valid = 1'b1; pt_x = 11'd4; pt_y = 11'd2;
        tick();
        pt_valid = 1'b0;
        tick();
        ce = 1'b0;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            pt_valid = 1'b1; pt_x = 11'd9;
            tick();
            spurious += int'(term_ce);
        end
        pt_valid = 1'b0;
        chk("freeze_no_ce", spurious, 0);
        ce = 1'b1;
        tick();
        chk("freeze_resume_ce", term_ce, 1);
        chk("freeze_xx", term_xx, 2);
        chk("freeze_yy", term_yy, 8);
        chk("freeze_xy", term_xy, -4);
        ce = 1'b0;
        tick(); tick(); tick();
        chk("freeze_hold_ce", term_ce, 1);
        chk("freeze_hold_yy", term_yy, 8);
        chk("freeze_count", pt_count, 1);
        ce = 1'b1;
        tick();
        chk("freeze_ce_drop", term_ce, 0);
        finish_frame("freeze");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
